onehot_encoder_fifo: RTL and testbench

ONEHOT_ENCODER_FIFO -- requirements
Module: onehot_encoder_fifo

---
 rtl/onehot_encoder_fifo_if.sv | 20 ++
 rtl/onehot_encoder_fifo.sv | 83 ++++++++
 tb/tb_onehot_encoder_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/onehot_encoder_fifo_if.sv
// Handshake bundle for the one-hot encoder FIFO: upstream push side and downstream pop side.
interface onehot_encoder_fifo_if;
  logic       in_valid;
  logic [3:0] in_word;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_code;
  logic       out_err;
  logic       out_ready;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_code, out_err
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_code, out_err
  );
endinterface

// File: rtl/onehot_encoder_fifo.sv
// Encodes one-hot 4-bit words to a 2-bit index plus error flag and queues them in a
// first-word-fall-through FIFO, with a saturating count of accepted non-one-hot words.
module onehot_encoder_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  onehot_encoder_fifo_if.slave   bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    mem [DEPTH];
  logic [1:0]    enc_code;
  logic          enc_err;
  logic          push;
  logic          pop;

  always_comb begin
    enc_code = '0;
    enc_err  = 1'b0;
    case (bus.in_word)
      4'b0001: enc_code = 2'd0;
      4'b0010: enc_code = 2'd1;
      4'b0100: enc_code = 2'd2;
      4'b1000: enc_code = 2'd3;
      default: enc_err  = 1'b1;
    endcase
  end

  // in_ready depends on stored level only, so a pop never opens a slot in the same cycle.
  assign bus.in_ready  = (level != FULL_LVL);
  assign bus.out_valid = (level != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Storage is not reset; the head is masked while empty so reset shows 00/0.
  always_comb begin
    bus.out_code = '0;
    bus.out_err  = 1'b0;
    if (bus.out_valid) begin
      bus.out_code = mem[rd_ptr][2:1];
      bus.out_err  = mem[rd_ptr][0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {enc_code, enc_err};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && enc_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_onehot_encoder_fifo.sv
// Directed bench for onehot_encoder_fifo: a DEPTH=4/CNT_W=8 instance and a DEPTH=8/CNT_W=2 instance.
module tb_onehot_encoder_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  onehot_encoder_fifo_if a_if ();
  onehot_encoder_fifo_if b_if ();
  logic [2:0] level_a;
  logic [7:0] err_a;
  logic [3:0] level_b;
  logic [1:0] err_b;

  onehot_encoder_fifo #(.DEPTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .level(level_a), .err_cnt(err_a)
  );
  onehot_encoder_fifo #(.DEPTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .level(level_b), .err_cnt(err_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bw [5] = '{4'b0000, 4'b0011, 4'b1111, 4'b0101, 4'b1001};
  logic [1:0] be [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] drain [4] = '{2'd2, 2'd1, 2'd0, 2'd0};

  initial begin
    a_if.in_valid = 1'b0; a_if.in_word = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_word = '0; b_if.out_ready = 1'b0;

    // Reset values while rst is high, before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_level", level_a, 0);
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_err_cnt", err_a, 0);
    check("rst_out_code", a_if.out_code, 0);
    check("rst_out_err", a_if.out_err, 0);
    check("rst_in_ready", a_if.in_ready, 1);
    step();
    rst = 1'b0;

    // Fill with the four one-hot words, no pops
    for (int i = 0; i < 4; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_word  = 4'b0001 << i;
      step();
      check("fill_level", level_a, i + 1);
      check("fill_out_valid", a_if.out_valid, 1);
      check("fill_head_code", a_if.out_code, 0);
      check("fill_in_ready", a_if.in_ready, (i < 3) ? 1 : 0);
    end
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_code", a_if.out_code, i);
      check("drain_err", a_if.out_err, 0);
      step();
      check("drain_level", level_a, 3 - i);
    end
    check("empty_out_valid", a_if.out_valid, 0);
    check("empty_in_ready", a_if.in_ready, 1);
    step();
    check("no_underflow", level_a, 0);
    a_if.out_ready = 1'b0;

    // Non-one-hot words
    a_if.in_valid = 1'b1;
    a_if.in_word  = 4'b0000;
    step();
    check("bad0_err_cnt", err_a, 1);
    check("bad0_level", level_a, 1);
    check("bad0_out_err", a_if.out_err, 1);
    check("bad0_out_code", a_if.out_code, 0);
    a_if.in_word = 4'b0110;
    step();
    check("bad1_err_cnt", err_a, 2);
    check("bad1_level", level_a, 2);
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    step();
    check("bad_pop1_err", a_if.out_err, 1);
    check("bad_pop1_code", a_if.out_code, 0);
    check("bad_pop1_level", level_a, 1);
    step();
    check("bad_pop2_level", level_a, 0);
    a_if.out_ready = 1'b0;

    // Full: blocked push has no effect; pop while full, then push next cycle
    a_if.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_if.in_word = 4'b1000 >> i;
      step();
    end
    check("full_level", level_a, 4);
    check("full_in_ready", a_if.in_ready, 0);
    a_if.in_word = 4'b0000;
    step();
    check("blocked_err_cnt", err_a, 2);
    check("blocked_level", level_a, 4);
    check("blocked_head", a_if.out_code, 3);
    a_if.in_word   = 4'b0001;
    a_if.out_ready = 1'b1;
    step();
    check("full_pop_level", level_a, 3);
    check("full_pop_in_ready", a_if.in_ready, 1);
    check("full_pop_head", a_if.out_code, 2);
    a_if.out_ready = 1'b0;
    step();
    check("refill_level", level_a, 4);
    check("refill_in_ready", a_if.in_ready, 0);
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_drain_code", a_if.out_code, drain[i]);
      check("full_drain_err", a_if.out_err, 0);
      step();
    end
    check("full_drain_level", level_a, 0);

    // Streaming push+pop every cycle across several pointer wraps
    a_if.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_if.in_word = 4'b0001 << (k % 4);
      step();
      check("stream_level", level_a, 1);
      check("stream_valid", a_if.out_valid, 1);
      check("stream_code", a_if.out_code, k % 4);
    end
    a_if.in_valid = 1'b0;
    step();
    check("stream_end_level", level_a, 0);
    a_if.out_ready = 1'b0;

    // Asynchronous reset mid-cycle with three entries stored
    a_if.in_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      a_if.in_word = 4'b0001 << i;
      step();
    end
    check("pre_rst_level", level_a, 3);
    a_if.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_level", level_a, 0);
    check("arst_out_valid", a_if.out_valid, 0);
    check("arst_in_ready", a_if.in_ready, 1);
    check("arst_err_cnt", err_a, 0);
    check("arst_out_code", a_if.out_code, 0);
    check("arst_out_err", a_if.out_err, 0);
    #1 rst = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.in_word  = 4'b0100;
    step();
    check("post_rst_level", level_a, 1);
    check("post_rst_code", a_if.out_code, 2);
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;
    step();
    check("post_rst_empty", a_if.out_valid, 0);
    a_if.out_ready = 1'b0;

    // Narrow error counter saturates at 3
    b_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_if.in_word = bw[i];
      step();
      check("sat_err_cnt", err_b, be[i]);
      check("sat_level", level_b, i + 1);
    end
    b_if.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
